// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider: operation codes, FSM states,
// the divide-by-zero quotient and the signed-overflow dividend pattern.
package div_pkg;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } div_state_t;

   // Widest XLEN the constants below cover; users truncate to their own width.
   localparam int DIV_MAX_XLEN = 64;

   localparam logic [DIV_MAX_XLEN-1:0] DIV_ZERO_QUOTIENT = '1;

   // Most negative value for a given XLEN (only the MSB set).
   function automatic logic [DIV_MAX_XLEN-1:0] div_ovf_dividend(input int xlen);
      return {{(DIV_MAX_XLEN-1){1'b0}}, 1'b1} << (xlen - 1);
   endfunction

endpackage

// File: rtl/adder.sv
// Generic add/subtract primitive: sum = a + b, or a - b when sub is high.
// Purely combinational.
module adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum
);

   assign sum = a + (sub ? ~b : b) + {{(WIDTH-1){1'b0}}, sub};

endmodule

// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU; result with a one-cycle o_done pulse,
// XLEN+2 cycles after start (1 cycle for /0 and signed overflow). Optional i_flush via DIV_ITER_FLUSH_EN.
module div_iter_unit
   import div_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  div_op_t         i_op,
   input  logic [XLEN-1:0] i_dividend,
   input  logic [XLEN-1:0] i_divisor,
`ifdef DIV_ITER_FLUSH_EN
   input  logic            i_flush,
`endif
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] ONES = XLEN'(DIV_ZERO_QUOTIENT);
   localparam logic [XLEN-1:0] OVF  = XLEN'(div_ovf_dividend(XLEN));

   div_state_t      state, state_n;
   logic            accept;
   logic            sel_rem, qneg, rneg;
   logic [XLEN-1:0] dvd, dvs, quo, rem, result;
   logic [CW-1:0]   cnt;
   logic            flush;

`ifdef DIV_ITER_FLUSH_EN
   assign flush = i_flush;
`else
   assign flush = 1'b0;
`endif

   logic            is_signed, a_neg, b_neg, div_zero, sgn_ovf, special;
   logic [XLEN-1:0] a_mag, b_mag;

   assign is_signed = ~i_op[0];
   assign a_neg     = is_signed & i_dividend[XLEN-1];
   assign b_neg     = is_signed & i_divisor[XLEN-1];
   assign a_mag     = a_neg ? -i_dividend : i_dividend;
   assign b_mag     = b_neg ? -i_divisor : i_divisor;
   assign div_zero  = (i_divisor == '0);
   assign sgn_ovf   = is_signed && (i_dividend == OVF) && (i_divisor == ONES);
   assign special   = div_zero | sgn_ovf;

   // Partial remainder never exceeds the divisor, so only XLEN bits are stored;
   // the XLEN+1-bit shifted value and trial difference exist only combinationally.
   logic [XLEN:0] shifted, trial;
   assign shifted = {rem, dvd[XLEN-1]};

   adder #(.WIDTH(XLEN + 1)) u_adder (
      .a   (shifted),
      .b   ({1'b0, dvs}),
      .sub (1'b1),
      .sum (trial)
   );

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      case (state)
         IDLE: if (i_start && !flush) begin
            accept  = 1'b1;
            state_n = special ? DONE : CALC;
         end
         CALC: if (cnt == '0) state_n = FIX;
         FIX:  state_n = DONE;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (flush && state != IDLE) state_n = IDLE;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sel_rem <= 1'b0;
         qneg    <= 1'b0;
         rneg    <= 1'b0;
         dvd     <= '0;
         dvs     <= '0;
         quo     <= '0;
         rem     <= '0;
         cnt     <= '0;
         result  <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               sel_rem <= i_op[1];
               qneg    <= a_neg ^ b_neg;
               rneg    <= a_neg;
               dvd     <= a_mag;
               dvs     <= b_mag;
               quo     <= '0;
               rem     <= '0;
               cnt     <= CW'(XLEN - 1);
               if (div_zero)     result <= i_op[1] ? i_dividend : ONES;
               else if (sgn_ovf) result <= i_op[1] ? '0 : OVF;
            end
            CALC: begin
               rem <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
               quo <= {quo[XLEN-2:0], ~trial[XLEN]};
               dvd <= {dvd[XLEN-2:0], 1'b0};
               cnt <= cnt - 1'b1;
            end
            FIX: if (!flush) begin
               if (sel_rem) result <= rneg ? -rem : rem;
               else         result <= qneg ? -quo : quo;
            end
            default: ;
         endcase
      end
   end

   assign o_busy   = (state != IDLE);
   assign o_done   = (state == DONE) && !flush;
   assign o_result = result;

endmodule

// File: tb/tb_div_iter_unit.sv
// Randomized bench for div_iter_unit against a plain-arithmetic reference model,
// with a per-cycle monitor checking busy/done/result timing and a set of pinned literal cases.
module tb_div_iter_unit;
   import div_pkg::*;

   localparam int XLEN = 32;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_start = 1'b0;
   div_op_t     i_op = DIVU;
   logic [31:0] i_dividend = '0;
   logic [31:0] i_divisor = '0;
`ifdef DIV_ITER_FLUSH_EN
   logic        i_flush = 1'b0;
`endif
   logic        o_busy, o_done;
   logic [31:0] o_result;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          n_done = 0;
   int          n_ops = 0;
   bit          pend = 1'b0;
   int          acc_cyc = 0;
   int          due_cyc = 0;
   logic [31:0] exp_res = '0;
   logic [31:0] last_res = '0;

   div_iter_unit #(.XLEN(XLEN)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_start    (i_start),
      .i_op       (i_op),
      .i_dividend (i_dividend),
      .i_divisor  (i_divisor),
`ifdef DIV_ITER_FLUSH_EN
      .i_flush    (i_flush),
`endif
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_result   (o_result)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return op[1] ? 32'd0 : 32'h8000_0000;
      case (op)
         2'd0:    return $signed(a) / $signed(b);
         2'd1:    return a / b;
         2'd2:    return $signed(a) % $signed(b);
         default: return a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
      return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Every cycle: while an accepted op is in flight busy must be high and done must
   // pulse exactly on the predicted cycle with the model result; otherwise both low.
   always begin
      @(posedge i_clk);
      cyc++;
      #1;
      if (pend && cyc >= acc_cyc) begin
         check("busy", {31'd0, o_busy}, 32'd1);
         check("done_timing", {31'd0, o_done}, {31'd0, cyc == due_cyc});
         if (cyc == due_cyc) begin
            check("result", o_result, exp_res);
            last_res = o_result;
            n_done++;
            pend = 1'b0;
         end
      end else begin
         check("busy_idle", {31'd0, o_busy}, 32'd0);
         check("done_idle", {31'd0, o_done}, 32'd0);
      end
   end

   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge i_clk);
      i_op       = div_op_t'(op);
      i_dividend = a;
      i_divisor  = b;
      i_start    = 1'b1;
      exp_res    = ref_div(op, a, b);
      acc_cyc    = cyc + 1;
      due_cyc    = acc_cyc + (is_special(op, a, b) ? 0 : XLEN + 1);
      pend       = 1'b1;
      n_ops++;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 100 && pend; k++) @(negedge i_clk);
      check("timeout", {31'd0, pend}, 32'd0);
      pend = 1'b0;
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold);
      launch(op, a, b);
      if (!hold) begin
         @(negedge i_clk);
         i_start = 1'b0;
      end
      wait_done();
      if (hold) begin
         // keep start high through the DONE->IDLE edge; it must not be re-accepted there
         @(negedge i_clk);
         i_start = 1'b0;
      end
   endtask

   task automatic pinned(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit);
      check({name, "_model"}, ref_div(op, a, b), lit);
      run_op(op, a, b, 1'b0);
      check(name, last_res, lit);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         4:       return -32'($urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      repeat (3) @(negedge i_clk);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_done", {31'd0, o_done}, 32'd0);
      check("rst_result", o_result, 32'd0);
      i_rst = 1'b0;
      @(negedge i_clk);

      pinned("divu_100_7", 2'd1, 32'd100, 32'd7, 32'd14);
      pinned("remu_100_7", 2'd3, 32'd100, 32'd7, 32'd2);
      pinned("div_m7_2",   2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      pinned("rem_m7_2",   2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      pinned("rem_7_m2",   2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1);
      pinned("div_5_0",    2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF);
      pinned("remu_5_0",   2'd3, 32'd5, 32'd0, 32'd5);
      pinned("div_ovf",    2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      pinned("rem_ovf",    2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      pinned("divu_ovf_pattern", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

      // Reset mid-operation aborts without a done pulse.
      launch(2'd1, 32'd100, 32'd7);
      @(negedge i_clk);
      i_start = 1'b0;
      repeat (9) @(negedge i_clk);
      i_rst = 1'b1;
      pend  = 1'b0;
      n_ops--;
      @(negedge i_clk);
      check("abort_busy", {31'd0, o_busy}, 32'd0);
      check("abort_result", o_result, 32'd0);
      i_rst = 1'b0;
      repeat (40) @(negedge i_clk);
      pinned("divu_9_3", 2'd1, 32'd9, 32'd3, 32'd3);

      // Start held high across a busy op: one acceptance, one done.
      run_op(2'd0, 32'd1000, 32'hFFFF_FFF6, 1'b1);
      check("held_start", last_res, 32'hFFFF_FF9C);
      repeat (3) @(negedge i_clk);

`ifdef DIV_ITER_FLUSH_EN
      launch(2'd1, 32'd100, 32'd7);
      @(negedge i_clk);
      i_start = 1'b0;
      repeat (4) @(negedge i_clk);
      i_flush = 1'b1;
      pend    = 1'b0;
      n_ops--;
      @(negedge i_clk);
      i_flush = 1'b0;
      check("flush_busy", {31'd0, o_busy}, 32'd0);
      @(negedge i_clk);
      i_flush = 1'b1;
      i_start = 1'b1;
      @(negedge i_clk);
      i_flush = 1'b0;
      i_start = 1'b0;
      check("flush_blocks_start", {31'd0, o_busy}, 32'd0);
      repeat (3) @(negedge i_clk);
`endif

      for (int i = 0; i < 300; i++) begin
         logic [1:0]  op;
         logic [31:0] a, b;
         op = 2'($urandom_range(0, 3));
         a  = pick();
         b  = pick();
         if ($urandom_range(0, 15) == 0) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         run_op(op, a, b, ($urandom_range(0, 9) == 0));
         repeat ($urandom_range(0, 2)) @(negedge i_clk);
      end

      repeat (5) @(negedge i_clk);
      check("done_count", n_done, n_ops);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule
